// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM driving every datapath control and bus strobe
module mc_ctrl_fsm #(
  parameter bit OVF_TRAP = 1'b1,
  parameter bit ILL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        lorD,
  output logic        ALUSrcA,
  output logic        S,
  output logic [1:0]  PCSource,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALU_Control,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ovf_trap,
  output logic        ill_trap,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    ST_IF, ST_ID, ST_EX_R, ST_WB_R, ST_EX_I, ST_WB_I, ST_MA, ST_MRD,
    ST_WBL, ST_MWR, ST_BR, ST_J, ST_JAL, ST_JR, ST_LUI, ST_RSV
  } state_t;
  localparam logic [2:0] A_AND = 3'd0, A_OR = 3'd1, A_ADD = 3'd2, A_XOR = 3'd3;
  localparam logic [2:0] A_NOR = 3'd4, A_SRL = 3'd5, A_SUB = 3'd6, A_SLT = 3'd7;
  state_t cur, nxt, id_next;
  logic ovf, trap, ovf_op, is_srl, unused_bits;
  logic [2:0] alu_r, alu_i;
  logic [5:0] op, fn;
  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign is_srl = fn == 6'h02;
  assign ovf_op = (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08;
  assign trap = OVF_TRAP && ovf;
  assign state = cur;
  // zero is consumed by the datapath's PC enable, not by the FSM itself
  assign unused_bits = ^{inst[25:6], zero};
  always_comb begin
    id_next = ST_IF;
    alu_r = A_ADD;
    alu_i = A_ADD;
    case (op)
      6'h00: begin
        id_next = ST_EX_R;
        case (fn)
          6'h20: alu_r = A_ADD;
          6'h22: alu_r = A_SUB;
          6'h24: alu_r = A_AND;
          6'h25: alu_r = A_OR;
          6'h26: alu_r = A_XOR;
          6'h27: alu_r = A_NOR;
          6'h02: alu_r = A_SRL;
          6'h2a: alu_r = A_SLT;
          6'h08: id_next = ST_JR;
          default: id_next = ST_IF;
        endcase
      end
      6'h23, 6'h2b: id_next = ST_MA;
      6'h04, 6'h05: id_next = ST_BR;
      6'h08: id_next = ST_EX_I;
      6'h0a: begin id_next = ST_EX_I; alu_i = A_SLT; end
      6'h0c: begin id_next = ST_EX_I; alu_i = A_AND; end
      6'h0d: begin id_next = ST_EX_I; alu_i = A_OR; end
      6'h0e: begin id_next = ST_EX_I; alu_i = A_XOR; end
      6'h0f: id_next = ST_LUI;
      6'h02: id_next = ST_J;
      6'h03: id_next = ST_JAL;
      default: id_next = ST_IF;
    endcase
  end
  always_comb begin
    nxt = ST_IF;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    Branch = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    lorD = 1'b0;
    ALUSrcA = 1'b0;
    S = 1'b0;
    PCSource = 2'b00;
    RegDst = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcB = 2'b00;
    ALU_Control = A_ADD;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    ovf_trap = 1'b0;
    ill_trap = 1'b0;
    case (cur)
      ST_IF: begin
        lorD = 1'b1;
        MemRead = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        IRWrite = MIO_ready;
        nxt = MIO_ready ? ST_ID : ST_IF;
      end
      ST_ID: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b11;
        nxt = id_next;
        ill_trap = ILL_TRAP && id_next == ST_IF;
      end
      ST_EX_R: begin
        ALU_Control = alu_r;
        ALUSrcA = is_srl;
        S = is_srl;
        nxt = ST_WB_R;
      end
      ST_WB_R: begin
        RegDst = 2'b01;
        RegWrite = !trap;
        ovf_trap = trap;
      end
      ST_EX_I: begin
        ALUSrcB = 2'b10;
        ALU_Control = alu_i;
        nxt = ST_WB_I;
      end
      ST_WB_I: begin
        RegWrite = !trap;
        ovf_trap = trap;
      end
      ST_MA: begin
        ALUSrcB = 2'b10;
        nxt = op[3] ? ST_MWR : ST_MRD;
      end
      ST_MRD: begin
        ALUSrcB = 2'b10;
        MemRead = 1'b1;
        nxt = MIO_ready ? ST_WBL : ST_MRD;
      end
      ST_WBL: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      ST_MWR: begin
        ALUSrcB = 2'b10;
        MemWrite = 1'b1;
        nxt = MIO_ready ? ST_IF : ST_MWR;
      end
      ST_BR: begin
        ALU_Control = A_SUB;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
        Branch = op[0];
      end
      ST_J: begin
        PCSource = 2'b10;
        PCWrite = 1'b1;
      end
      ST_JAL: begin
        PCSource = 2'b10;
        PCWrite = 1'b1;
        RegDst = 2'b10;
        MemtoReg = 2'b11;
        RegWrite = 1'b1;
      end
      ST_JR: begin
        PCSource = 2'b11;
        PCWrite = 1'b1;
      end
      ST_LUI: begin
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
      end
      default: nxt = ST_IF;
    endcase
    if (rst) begin
      PCWrite = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite = 1'b0;
      RegWrite = 1'b0;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      ovf_trap = 1'b0;
      ill_trap = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= ST_IF;
      ovf <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == ST_EX_R || cur == ST_EX_I) ovf <= ovf_op & overflow;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed checks of the multi-cycle control FSM against hand-computed control words
module tb_mc_ctrl_fsm;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b1;
  logic [31:0] inst = 32'h0;
  logic PCWrite, PCWriteCond, Branch, IRWrite, RegWrite, lorD, ALUSrcA, S;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcB;
  logic [2:0] ALU_Control;
  logic MemRead, MemWrite, ovf_trap, ill_trap;
  logic [3:0] state;
  logic [26:0] ctl;
  logic pc_en;
  int n_chk = 0, n_err = 0;
  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .inst(inst), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .lorD(lorD), .ALUSrcA(ALUSrcA), .S(S), .PCSource(PCSource),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control),
    .MemRead(MemRead), .MemWrite(MemWrite), .ovf_trap(ovf_trap), .ill_trap(ill_trap), .state(state)
  );
  always #5 clk = ~clk;
  // control word: state, {PCWrite,PCWriteCond,Branch,IRWrite,RegWrite,lorD,ALUSrcA,S},
  // {PCSource,RegDst,MemtoReg,ALUSrcB}, ALU_Control, {MemRead,MemWrite}, {ovf_trap,ill_trap}
  assign ctl = {state, PCWrite, PCWriteCond, Branch, IRWrite, RegWrite, lorD, ALUSrcA, S,
                PCSource, RegDst, MemtoReg, ALUSrcB, ALU_Control, MemRead, MemWrite, ovf_trap, ill_trap};
  assign pc_en = MIO_ready & (PCWrite | PCWriteCond & (Branch ^ zero));
  function automatic logic [26:0] cw(input logic [3:0] s, input logic [7:0] en, input logic [7:0] sel,
                                     input logic [2:0] alu, input logic [1:0] mem, input logic [1:0] tr);
    return {s, en, sel, alu, mem, tr};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ck(input string tag, input logic [26:0] exp);
    #1 check(tag, {5'd0, ctl}, {5'd0, exp});
  endtask
  task automatic ckpc(input string tag, input logic exp);
    #1 check(tag, {31'd0, pc_en}, {31'd0, exp});
  endtask
  task automatic stp;
    @(posedge clk);
    #1;
  endtask
  localparam logic [26:0] IF_RDY = 27'b0000_10010110_00000001_010_10_00;
  localparam logic [26:0] IF_WAIT = 27'b0000_10000110_00000001_010_10_00;
  localparam logic [26:0] IN_RST = 27'b0000_00000110_00000001_010_00_00;
  localparam logic [26:0] ID_OK = 27'b0001_00000010_00000011_010_00_00;
  initial begin
    stp;
    stp;
    ck("reset", IN_RST);
    rst = 1'b0;
    ck("if_first", IF_RDY);
    MIO_ready = 1'b0;
    ck("if_wait", IF_WAIT);
    stp;
    ck("if_held", IF_WAIT);
    MIO_ready = 1'b1;
    inst = 32'h8C480004;
    stp;
    ck("lw_id", ID_OK);
    stp;
    ck("lw_ma", cw(4'd6, 8'b0, 8'b00000010, 3'b010, 2'b00, 2'b00));
    MIO_ready = 1'b0;
    stp;
    for (int i = 0; i < 3; i++) begin
      ck("lw_mrd_wait", cw(4'd7, 8'b0, 8'b00000010, 3'b010, 2'b10, 2'b00));
      stp;
    end
    MIO_ready = 1'b1;
    ck("lw_mrd_rdy", cw(4'd7, 8'b0, 8'b00000010, 3'b010, 2'b10, 2'b00));
    stp;
    ck("lw_wbl", cw(4'd8, 8'b00001000, 8'b00000100, 3'b010, 2'b00, 2'b00));
    stp;
    ck("lw_done", IF_RDY);
    inst = 32'h10000003;
    stp;
    stp;
    zero = 1'b1;
    ck("beq_br", cw(4'd10, 8'b01000000, 8'b01000000, 3'b110, 2'b00, 2'b00));
    ckpc("beq_pc_z1", 1'b1);
    zero = 1'b0;
    ckpc("beq_pc_z0", 1'b0);
    stp;
    ck("beq_done", IF_RDY);
    inst = 32'h14000003;
    stp;
    stp;
    zero = 1'b1;
    ck("bne_br", cw(4'd10, 8'b01100000, 8'b01000000, 3'b110, 2'b00, 2'b00));
    ckpc("bne_pc_z1", 1'b0);
    zero = 1'b0;
    ckpc("bne_pc_z0", 1'b1);
    stp;
    inst = 32'h0C000010;
    stp;
    stp;
    ck("jal", cw(4'd12, 8'b10001000, 8'b10101100, 3'b010, 2'b00, 2'b00));
    stp;
    ck("jal_done", IF_RDY);
    inst = 32'h00430820;
    stp;
    stp;
    overflow = 1'b1;
    ck("add_ex", cw(4'd2, 8'b0, 8'b0, 3'b010, 2'b00, 2'b00));
    stp;
    overflow = 1'b0;
    ck("add_wb_ovf", cw(4'd3, 8'b0, 8'b00010000, 3'b010, 2'b00, 2'b10));
    stp;
    ck("ovf_one_cycle", IF_RDY);
    stp;
    stp;
    stp;
    ck("add_wb_ok", cw(4'd3, 8'b00001000, 8'b00010000, 3'b010, 2'b00, 2'b00));
    stp;
    inst = 32'h00430824;
    stp;
    stp;
    overflow = 1'b1;
    ck("and_ex", cw(4'd2, 8'b0, 8'b0, 3'b000, 2'b00, 2'b00));
    stp;
    overflow = 1'b0;
    ck("and_wb_noovf", cw(4'd3, 8'b00001000, 8'b00010000, 3'b010, 2'b00, 2'b00));
    stp;
    inst = 32'h00021042;
    stp;
    stp;
    ck("srl_ex", cw(4'd2, 8'b00000011, 8'b0, 3'b101, 2'b00, 2'b00));
    stp;
    stp;
    inst = 32'h20420001;
    stp;
    stp;
    ck("addi_ex", cw(4'd4, 8'b0, 8'b00000010, 3'b010, 2'b00, 2'b00));
    overflow = 1'b1;
    stp;
    overflow = 1'b0;
    ck("addi_wb_ovf", cw(4'd5, 8'b0, 8'b0, 3'b010, 2'b00, 2'b10));
    stp;
    inst = 32'h3C010005;
    stp;
    stp;
    ck("lui", cw(4'd14, 8'b00001000, 8'b00001000, 3'b010, 2'b00, 2'b00));
    stp;
    inst = 32'h03E00008;
    stp;
    stp;
    ck("jr", cw(4'd13, 8'b10000000, 8'b11000000, 3'b010, 2'b00, 2'b00));
    stp;
    inst = 32'hFC000000;
    stp;
    ck("ill_id", cw(4'd1, 8'b00000010, 8'b00000011, 3'b010, 2'b00, 2'b01));
    stp;
    ck("ill_done", IF_RDY);
    inst = 32'hAC480004;
    stp;
    stp;
    MIO_ready = 1'b0;
    stp;
    ck("sw_mwr", cw(4'd9, 8'b0, 8'b00000010, 3'b010, 2'b01, 2'b00));
    rst = 1'b1;
    ck("sw_rst_drop", cw(4'd9, 8'b0, 8'b00000010, 3'b010, 2'b00, 2'b00));
    stp;
    ck("sw_rst_if", IN_RST);
    rst = 1'b0;
    MIO_ready = 1'b1;
    ck("after_rst", IF_RDY);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
